// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [1:0] OP_SET_PADDLE = 2'd0;
    localparam logic [1:0] OP_READ_SCORE = 2'd1;
    localparam logic [1:0] OP_START      = 2'd2;
    localparam logic [1:0] OP_STATUS     = 2'd3;

    // STATUS word layout: {26'b0, winner[1:0], 2'b0, state[1:0]}
    localparam int STAT_STATE_LSB  = 0;
    localparam int STAT_WINNER_LSB = 4;

endpackage

// File: rtl/pong_score_bank.sv
// Per-player score counters: saturate at WIN_SCORE, lowest-index point wins,
// reports the would-be winning point combinationally so the FSM can react.
module pong_score_bank
    import pong_pkg::*;
#(
    parameter int N_PADDLES = 2,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 3
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic [N_PADDLES-1:0]         point,
    output logic [N_PADDLES*SCORE_W-1:0] scores,
    output logic                         hit,
    output logic                         win,
    output logic [1:0]                   win_idx
);

    localparam int IDX_W = (N_PADDLES > 2) ? 2 : 1;

    logic [N_PADDLES-1:0][SCORE_W-1:0] score_q;
    logic [IDX_W-1:0]                  sel;
    logic [SCORE_W-1:0]                new_score;

    // Descending scan so the lowest set bit is the last one assigned.
    always_comb begin
        sel = '0;
        for (int k = N_PADDLES - 1; k >= 0; k--) begin
            if (point[k]) sel = IDX_W'(k);
        end
        hit       = en && (|point);
        new_score = score_q[sel] + 1'b1;
        win       = hit && (new_score == SCORE_W'(WIN_SCORE));
        win_idx   = 2'(sel);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else if (clr) begin
            score_q <= '0;
        end else if (hit && (score_q[sel] != SCORE_W'(WIN_SCORE))) begin
            score_q[sel] <= new_score;
        end
    end

    assign scores = score_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: custom-instruction decode, game FSM, paddles, scores
// and registered VGA colour. Define PONG_PADDLE_CLAMP_EN to clamp paddle writes.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int          N_PADDLES = 2,
    parameter int          SCORE_W   = 4,
    parameter int          WIN_SCORE = 3,
    parameter int          V_RES     = 480,
    parameter int          PADDLE_H  = 64,
    parameter int          SERVE_DLY = 50_000_000,
    parameter logic [2:0]  FG_RGB    = 3'b101,
    parameter logic [2:0]  BG_RGB    = 3'b001
) (
    input  logic                         CLK,
    input  logic                         resentinho,
    input  logic                         pix_stb,
    input  logic                         ci_start,
    input  logic [1:0]                   ci_n,
    input  logic [31:0]                  ci_dataa,
    output logic [31:0]                  ci_result,
    output logic                         ci_done,
    input  logic [N_PADDLES-1:0]         point_i,
    output logic                         serve_o,
    output logic                         game_en,
    output logic [N_PADDLES*10-1:0]      paddle_y,
    output logic [N_PADDLES*SCORE_W-1:0] scores,
    output logic [1:0]                   winner,
    input  logic                         active,
    input  logic [3:0]                   layer_hit,
    output logic                         VGA_R,
    output logic                         VGA_G,
    output logic                         VGA_B
);

    localparam int         IDX_W = (N_PADDLES > 2) ? 2 : 1;
    localparam int         CNT_W = (SERVE_DLY > 1) ? $clog2(SERVE_DLY + 1) : 1;
    localparam logic [9:0] Y_MAX = 10'(V_RES - PADDLE_H);
    localparam logic [9:0] Y_MID = 10'((V_RES - PADDLE_H) / 2);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            serve_cnt;
    logic                        serve_d;
    logic [N_PADDLES-1:0][9:0]   paddle_q;
    logic [1:0]                  winner_q;
    logic [2:0]                  rgb_q;

    logic                        start_ok;
    logic                        pt_hit, pt_win;
    logic [1:0]                  pt_idx;

    logic [IDX_W-1:0]            wr_idx;
    logic [9:0]                  old_y, req_y, new_y;
    logic                        oor, rej, wr_en;
    logic [31:0]                 result_d;
    logic                        unused_bits;

    assign game_en  = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign start_ok = ci_start && (ci_n == OP_START) &&
                      ((state_q == ST_IDLE) || (state_q == ST_OVER));

    pong_score_bank #(
        .N_PADDLES (N_PADDLES),
        .SCORE_W   (SCORE_W),
        .WIN_SCORE (WIN_SCORE)
    ) u_scores (
        .CLK     (CLK),
        .rst_n   (resentinho),
        .clr     (start_ok),
        .en      (state_q == ST_PLAY),
        .point   (point_i),
        .scores  (scores),
        .hit     (pt_hit),
        .win     (pt_win),
        .win_idx (pt_idx)
    );

    always_ff @(posedge CLK or negedge resentinho) begin
        if (!resentinho) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        serve_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_SERVE;
            ST_SERVE: if (serve_cnt == CNT_W'(SERVE_DLY - 1)) begin
                state_d = ST_PLAY;
                serve_d = 1'b1;
            end
            ST_PLAY:  if (pt_hit) state_d = pt_win ? ST_OVER : ST_SERVE;
            ST_OVER:  if (start_ok) state_d = ST_SERVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter idles at zero outside SERVE, so every entry restarts the delay.
    always_ff @(posedge CLK or negedge resentinho) begin
        if (!resentinho) begin
            serve_cnt <= '0;
            serve_o   <= 1'b0;
            winner_q  <= '0;
        end else begin
            serve_cnt <= (state_q == ST_SERVE) ? serve_cnt + 1'b1 : '0;
            serve_o   <= serve_d;
            if ((state_q == ST_PLAY) && pt_win) winner_q <= pt_idx;
        end
    end

    assign winner = winner_q;

    always_comb begin
        wr_idx = ci_dataa[16 +: IDX_W];
        old_y  = paddle_q[wr_idx];
        req_y  = ci_dataa[9:0];
        oor    = req_y > Y_MAX;
`ifdef PONG_PADDLE_CLAMP_EN
        new_y  = oor ? Y_MAX : req_y;
        rej    = 1'b0;
`else
        new_y  = oor ? old_y : req_y;
        rej    = oor;
`endif
        if (!game_en) begin
            new_y = old_y;
            rej   = 1'b0;
        end
        wr_en = ci_start && (ci_n == OP_SET_PADDLE) && game_en;
    end

    always_comb begin
        result_d = '0;
        case (ci_n)
            OP_SET_PADDLE: result_d = {rej, 21'b0, new_y};
            OP_READ_SCORE: result_d = 32'(scores);
            OP_START:      result_d = '0;
            OP_STATUS: begin
                result_d[STAT_STATE_LSB  +: 2] = state_q;
                result_d[STAT_WINNER_LSB +: 2] = winner_q;
            end
            default:       result_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge resentinho) begin
        if (!resentinho) begin
            ci_done   <= 1'b0;
            ci_result <= '0;
        end else begin
            ci_done <= ci_start;
            if (ci_start) ci_result <= result_d;
        end
    end

    always_ff @(posedge CLK or negedge resentinho) begin
        if (!resentinho) begin
            for (int k = 0; k < N_PADDLES; k++) paddle_q[k] <= Y_MID;
        end else if (start_ok) begin
            for (int k = 0; k < N_PADDLES; k++) paddle_q[k] <= Y_MID;
        end else if (wr_en) begin
            paddle_q[wr_idx] <= new_y;
        end
    end

    assign paddle_y = paddle_q;

    always_ff @(posedge CLK or negedge resentinho) begin
        if (!resentinho)  rgb_q <= 3'b000;
        else if (pix_stb) rgb_q <= !active ? 3'b000 : ((|layer_hit) ? FG_RGB : BG_RGB);
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;

    assign unused_bits = ^{ci_dataa[31:10]};

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with N_PADDLES=2, WIN_SCORE=3, SERVE_DLY=4.
module tb_pong_game_ctrl;

    logic        CLK = 1'b0;
    logic        resentinho;
    logic        pix_stb;
    logic        ci_start;
    logic [1:0]  ci_n;
    logic [31:0] ci_dataa;
    logic [31:0] ci_result;
    logic        ci_done;
    logic [1:0]  point_i;
    logic        serve_o;
    logic        game_en;
    logic [19:0] paddle_y;
    logic [7:0]  scores;
    logic [1:0]  winner;
    logic        active;
    logic [3:0]  layer_hit;
    logic        VGA_R, VGA_G, VGA_B;

    int n_pass  = 0;
    int n_total = 0;

    pong_game_ctrl #(
        .N_PADDLES (2),
        .SCORE_W   (4),
        .WIN_SCORE (3),
        .V_RES     (480),
        .PADDLE_H  (64),
        .SERVE_DLY (4)
    ) dut (
        .CLK        (CLK),
        .resentinho (resentinho),
        .pix_stb    (pix_stb),
        .ci_start   (ci_start),
        .ci_n       (ci_n),
        .ci_dataa   (ci_dataa),
        .ci_result  (ci_result),
        .ci_done    (ci_done),
        .point_i    (point_i),
        .serve_o    (serve_o),
        .game_en    (game_en),
        .paddle_y   (paddle_y),
        .scores     (scores),
        .winner     (winner),
        .active     (active),
        .layer_hit  (layer_hit),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic cmd(input string tag, input logic [1:0] op, input logic [31:0] d,
                       input logic [31:0] exp);
        ci_start = 1'b1; ci_n = op; ci_dataa = d;
        step();
        ci_start = 1'b0;
        chk({tag, "_done"}, 32'(ci_done), 32'd1);
        chk(tag, ci_result, exp);
        step();
        chk({tag, "_done_fall"}, 32'(ci_done), 32'd0);
    endtask

    task automatic point(input logic [1:0] p);
        point_i = p;
        step();
        point_i = 2'b00;
    endtask

    task automatic wait_serve(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (serve_o) break;
            step();
        end
        chk(tag, 32'(serve_o), 32'd1);
    endtask

    initial begin
        resentinho = 1'b0; pix_stb = 1'b0; ci_start = 1'b0; ci_n = 2'd0;
        ci_dataa = '0; point_i = 2'b00; active = 1'b0; layer_hit = 4'b0;
        step(); step();
        chk("rst_paddles", 32'(paddle_y), {12'b0, 10'd208, 10'd208});
        chk("rst_scores",  32'(scores), 32'd0);
        chk("rst_outs",    32'({serve_o, ci_done, game_en, winner}), 32'd0);
        chk("rst_result",  ci_result, 32'd0);
        chk("rst_vga",     32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        resentinho = 1'b1;
        step();
        cmd("status_idle", 2'd3, 32'd0, 32'd0);

        // compositor
        pix_stb = 1'b1; active = 1'b1; layer_hit = 4'b0000; step();
        chk("vga_bg", 32'({VGA_R, VGA_G, VGA_B}), 32'b001);
        layer_hit = 4'b0100; step();
        chk("vga_fg", 32'({VGA_R, VGA_G, VGA_B}), 32'b101);
        active = 1'b0; step();
        chk("vga_blank", 32'({VGA_R, VGA_G, VGA_B}), 32'b000);
        pix_stb = 1'b0; active = 1'b1; layer_hit = 4'b0000; step();
        chk("vga_hold", 32'({VGA_R, VGA_G, VGA_B}), 32'b000);

        // START then back-to-back SET_PADDLE; serve timing from SERVE entry
        ci_start = 1'b1; ci_n = 2'd2; ci_dataa = '0;
        step();
        chk("start_done", 32'(ci_done), 32'd1);
        chk("start_res",  ci_result, 32'd0);
        chk("start_en",   32'(game_en), 32'd1);
        ci_n = 2'd0; ci_dataa = (32'd1 << 16) | 32'd100;
        step();
        ci_start = 1'b0;
        chk("setp_done", 32'(ci_done), 32'd1);
        chk("setp_res",  ci_result, 32'd100);
        chk("setp_y1",   32'(paddle_y[19:10]), 32'd100);
        chk("serve_c2",  32'(serve_o), 32'd0);
        step();
        chk("setp_fall", 32'(ci_done), 32'd0);
        chk("serve_c3",  32'(serve_o), 32'd0);
        step();
        chk("serve_c4",  32'(serve_o), 32'd0);
        step();
        chk("serve_c5",  32'(serve_o), 32'd1);
        step();
        chk("serve_c6",  32'(serve_o), 32'd0);

        // out-of-range paddle write in PLAY
`ifdef PONG_PADDLE_CLAMP_EN
        cmd("oor_res", 2'd0, (32'd1 << 16) | 32'd500, 32'd416);
        chk("oor_y1",  32'(paddle_y[19:10]), 32'd416);
`else
        cmd("oor_res", 2'd0, (32'd1 << 16) | 32'd500, 32'h8000_0064);
        chk("oor_y1",  32'(paddle_y[19:10]), 32'd100);
`endif

        // simultaneous points: player 0 takes it
        point(2'b11);
        chk("pt_prio",  32'(scores), 32'h01);
        cmd("pt_state", 2'd3, 32'd0, 32'd1);
        cmd("rd_score", 2'd1, 32'd0, 32'h01);
        wait_serve("serve_a");
        step();

        // player 1 to the win
        point(2'b10); chk("p1_a", 32'(scores), 32'h11);
        wait_serve("serve_b"); step();
        point(2'b10); chk("p1_b", 32'(scores), 32'h21);
        wait_serve("serve_c"); step();
        point(2'b10); chk("p1_c", 32'(scores), 32'h31);
        chk("over_en",     32'(game_en), 32'd0);
        chk("over_winner", 32'(winner), 32'd1);
        cmd("over_status", 2'd3, 32'd0, 32'h13);
        cmd("over_setp",   2'd0, 32'd50, 32'd208);
        chk("over_y0",     32'(paddle_y[9:0]), 32'd208);
        cmd("restart",     2'd2, 32'd0, 32'd0);
        chk("restart_sc",  32'(scores), 32'd0);
        chk("restart_y",   32'(paddle_y), {12'b0, 10'd208, 10'd208});

        // reach PLAY with score 2 then reset with a command in flight
        wait_serve("serve_d"); step();
        point(2'b01); wait_serve("serve_e"); step();
        point(2'b01); wait_serve("serve_f"); step();
        chk("pre_rst_sc", 32'(scores), 32'h02);
        chk("pre_rst_en", 32'(game_en), 32'd1);
        ci_start = 1'b1; ci_n = 2'd3;
        #2 resentinho = 1'b0;
        #1;
        chk("arst_sc",   32'(scores), 32'd0);
        chk("arst_en",   32'(game_en), 32'd0);
        chk("arst_done", 32'(ci_done), 32'd0);
        step();
        ci_start = 1'b0;
        chk("arst_done2", 32'(ci_done), 32'd0);
        resentinho = 1'b1;
        step();
        chk("arst_done3", 32'(ci_done), 32'd0);
        cmd("arst_status", 2'd3, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised game controller for the Pong display pipeline. It replaces the ad-hoc enable, paddle and colour logic of the current top level with one block that owns all game state. The Nios II multicycle custom instruction drives it. Ball-engine point events feed it. It outputs paddle positions, scores, a serve pulse and the registered 1-bit-per-channel VGA colour. It sits between the custom-instruction port and the `vga640x480` / print modules.

## Interface
Parameters:
- `N_PADDLES`, 2: number of players/paddles, legal values 2 or 4.
- `SCORE_W`, 4: width of each player score.
- `WIN_SCORE`, 3: score that ends the game, 1..2^SCORE_W-1.
- `V_RES`, 480: visible lines.
- `PADDLE_H`, 64: paddle height in lines.
- `SERVE_DLY`, 50_000_000: cycles spent in SERVE before the serve pulse.
- `FG_RGB`, 3'b101: {R,G,B} when any layer hits.
- `BG_RGB`, 3'b001: {R,G,B} in the active area with no hit.

Ports:
- `CLK`, in, 1: the single clock for the whole block.
- `resentinho`, in, 1: asynchronous active-low reset.
- `pix_stb`, in, 1: pixel-rate enable for the compositor.
- `ci_start`, in, 1: custom-instruction request, one cycle.
- `ci_n`, in, 2: opcode.
- `ci_dataa`, in, 32: operand.
- `ci_result`, out, 32: response data.
- `ci_done`, out, 1: response strobe.
- `point_i`, in, N_PADDLES: one-hot point pulse from the ball engine; bit k means player k scored.
- `serve_o`, out, 1: one-cycle pulse telling the ball engine to launch.
- `game_en`, out, 1: high in SERVE or PLAY.
- `paddle_y`, out, N_PADDLES*10: top line of each paddle.
- `scores`, out, N_PADDLES*SCORE_W: packed scores, player 0 in the LSBs.
- `winner`, out, 2: index of the winning player, valid in OVER.
- `active`, in, 1: VGA active area.
- `layer_hit`, in, 4: menu/paddle/ball hit flags.
- `VGA_R`, `VGA_G`, `VGA_B`, out, 1 each: registered colour.

## Operation
- States: IDLE, SERVE, PLAY, OVER.
  - IDLE -> SERVE on START.
  - SERVE -> PLAY when the delay counter reaches SERVE_DLY-1; `serve_o` pulses on that transition.
  - PLAY -> SERVE on a point when the new score < WIN_SCORE.
  - PLAY -> OVER when the new score == WIN_SCORE; `winner` is latched.
  - OVER -> SERVE on START.
- Opcodes (`ci_n`):
  - 0 SET_PADDLE: index = `ci_dataa[17:16]` (masked to log2 N_PADDLES bits), y = `ci_dataa[9:0]`. Applied only when `game_en`=1; otherwise the paddle is unchanged. `ci_result` = the paddle's resulting y, zero-extended.
  - 1 READ_SCORE: `ci_result` = `scores`, zero-extended.
  - 2 START: valid in IDLE or OVER. Clears all scores, recentres all paddles, loads the serve counter. Ignored in SERVE and PLAY. `ci_result` = 0.
  - 3 STATUS: `ci_result` = {26'b0, winner[1:0], 2'b0, state[1:0]}.
- Point handling: `point_i` is evaluated only in PLAY. If more than one bit is set, the lowest index wins and the other bits are dropped. Scores never wrap, because the game ends at WIN_SCORE.
- Compositor, on `pix_stb` only: `active`=0 gives 000; `active`=1 with any `layer_hit` bit gives FG_RGB; otherwise BG_RGB.

## Timing
- Reset values:
  - state IDLE, all scores 0, `winner` 0.
  - every `paddle_y` = (V_RES-PADDLE_H)/2.
  - `serve_o`, `ci_done`, `ci_result`, VGA = 0.
  - `game_en` = 0.
- `ci_done` is high exactly one cycle, the cycle after `ci_start`; `ci_result` is valid in that same cycle and is held afterwards.
- Back-to-back `ci_start` is accepted every cycle.
- A paddle write is visible on `paddle_y` with the same one-cycle latency as `ci_done`.
- A point is reflected in `scores` and the state one cycle after `point_i`.
- The serve delay is exactly SERVE_DLY cycles in SERVE.
- VGA outputs change one `pix_stb` cycle after their inputs.
- Reset asserted mid-game aborts immediately to the reset values; a pending `ci_done` is dropped.

## Configuration
- `PONG_PADDLE_CLAMP_EN` defined: an out-of-range y (> V_RES-PADDLE_H) is clamped to V_RES-PADDLE_H and `ci_result[31]`=0.
- Undefined: an out-of-range write is rejected, the paddle is unchanged, and `ci_result[31]`=1 with the old y in `ci_result[9:0]`.

## Structure
- `pong_pkg` holds:
  - the state enum;
  - the opcode constants `OP_SET_PADDLE`/`OP_READ_SCORE`/`OP_START`/`OP_STATUS`;
  - the STATUS field positions.
- One sub-module, `pong_score_bank`: N_PADDLES saturating-at-win counters with clear, lowest-index priority select, and win/winner detection.

## Test plan
Bench parameters: N_PADDLES=2, V_RES=480, PADDLE_H=64, WIN_SCORE=3, SERVE_DLY=4.
- Reset -> `paddle_y` = {208,208}, STATUS result = 0, VGA = 000.
- START then SET_PADDLE idx1 y=100 -> `ci_done` one cycle after each `ci_start`; `paddle_y[19:10]`=100; `serve_o` pulses exactly 4 cycles after entering SERVE.
- SET_PADDLE y=500 -> with the macro, y=416 and bit31=0; without it, y is unchanged and bit31=1.
- In PLAY, `point_i`=2'b11 -> only score0 increments; state returns to SERVE.
- Three points to player 1 -> state OVER, `winner`=1, `game_en`=0; a later SET_PADDLE leaves y unchanged; START clears scores to 0.
- `resentinho` low while in PLAY with score 2 -> immediate IDLE, scores 0, no `ci_done` emitted for an in-flight command.
